// File: rtl/ram_tdp_pkg.sv
// ram_tdp_pkg
//  Shared definitions for the true dual-port RAM slice.
//  Contents:
//   RAM_READ_FIRST / RAM_WRITE_FIRST  same-port read-during-write selectors
//   ram_state_e                       clear sequencer states (ST_CLEAR, ST_RUN)
//   pick_byte()                       byte-lane select used for write-first merging
package ram_tdp_pkg;

    localparam int RAM_READ_FIRST  = 0;
    localparam int RAM_WRITE_FIRST = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_e;

    function automatic logic [7:0] pick_byte(input logic       take_new,
                                             input logic [7:0] new_byte,
                                             input logic [7:0] old_byte);
        return take_new ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_tdp_if.sv
// ram_tdp_if
//  Request/response bundle for both ports of ram_tdp.
//  Signals:
//   ready                    RAM accepts requests
//   en_x, we_x, addr_x       port x request, byte write enables, word address
//   wdata_x                  port x write data
//   rdata_x, rvalid_x        port x read data and one-cycle valid strobe
//  Modports:
//   master  requester side (CPU / DMA / testbench)
//   slave   RAM side
interface ram_tdp_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;

    logic                  ready;

    logic                  en_a;
    logic [DATA_BYTES-1:0] we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] wdata_a;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic                  rvalid_a;

    logic                  en_b;
    logic [DATA_BYTES-1:0] we_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wdata_b;
    logic [DATA_WIDTH-1:0] rdata_b;
    logic                  rvalid_b;

    modport master (
        input  ready,
        output en_a, we_a, addr_a, wdata_a,
        input  rdata_a, rvalid_a,
        output en_b, we_b, addr_b, wdata_b,
        input  rdata_b, rvalid_b
    );

    modport slave (
        output ready,
        input  en_a, we_a, addr_a, wdata_a,
        output rdata_a, rvalid_a,
        input  en_b, we_b, addr_b, wdata_b,
        output rdata_b, rvalid_b
    );

endinterface

// File: rtl/ram_tdp_rd_pipe.sv
// ram_rd_pipe
//  Read return path for one RAM port. The first stage captures the raw word
//  on the accept edge (synchronous read); an optional second stage adds one
//  more cycle of latency. Data holds between strobes, reset clears everything.
//  Ports:
//   clk, reset   clock and synchronous active-high reset
//   accept       request accepted at this edge
//   raw_word     word to return for this request (already RDW-resolved)
//   rdata        read data, held until the next rvalid
//   rvalid       one-cycle strobe marking new rdata
module ram_rd_pipe
    import ram_tdp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  accept,
    input  logic [DATA_WIDTH-1:0] raw_word,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_valid_q, s1_valid_d;

    always_comb begin
        s1_valid_d = accept;
        s1_data_d  = s1_data_q;
        if (accept) begin
            s1_data_d = raw_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
            logic                  s2_valid_q, s2_valid_d;

            // Second stage only reloads on a valid first stage so the
            // returned word stays stable between strobes.
            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s2_data_q;
                if (s1_valid_q) begin
                    s2_data_d = s1_data_q;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_data_q  <= s2_data_d;
                    s2_valid_q <= s2_valid_d;
                end
            end

            assign rdata  = s2_data_q;
            assign rvalid = s2_valid_q;
        end else begin : g_no_out_reg
            assign rdata  = s1_data_q;
            assign rvalid = s1_valid_q;
        end
    endgenerate

endmodule

// File: rtl/ram_tdp.sv
// ram_tdp
//  True dual-port synchronous RAM with byte enables, selectable same-port
//  read-during-write behaviour, optional output register, on-reset clear
//  sequencer and per-port read-valid strobes. Port A serves the CPU datapath,
//  port B DMA/debug masters.
//  Ports:
//   clk     clock, all logic on posedge
//   reset   synchronous active-high reset
//   bus     ram_tdp_if slave modport (ready, both request ports, both returns)
module ram_tdp
    import ram_tdp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_BYTES     = DATA_WIDTH / 8,
    parameter int OUT_REG        = 0,
    parameter int READ_MODE      = RAM_READ_FIRST,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic       clk,
    input  logic       reset,
    ram_tdp_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ram_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  ready_q, ready_d;
    logic                  clr_we;

    logic                  accept_a, accept_b;
    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] raw_a, raw_b;

    assign bus.ready = ready_q;

    // Requests are ignored in the reset cycle so a stale ready cannot let a
    // write slip through while the sequencer restarts.
    assign accept_a = bus.en_a & ready_q & ~reset;
    assign accept_b = bus.en_b & ready_q & ~reset;

    // Clear sequencer: walk every address once, writing zero, and stop on the
    // last address by compare so the counter never wraps into RUN.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = ST_RUN;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
        end
    end

    // Read words. Other-port writes land at the same edge, so the stored word
    // is always the pre-write value; write-first only merges this port's bytes.
    always_comb begin
        old_a = mem[bus.addr_a];
        old_b = mem[bus.addr_b];
        raw_a = old_a;
        raw_b = old_b;
        if (READ_MODE == RAM_WRITE_FIRST) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                raw_a[i*8 +: 8] = pick_byte(bus.we_a[i], bus.wdata_a[i*8 +: 8], old_a[i*8 +: 8]);
                raw_b[i*8 +: 8] = pick_byte(bus.we_b[i], bus.wdata_b[i*8 +: 8], old_b[i*8 +: 8]);
            end
        end
    end

    // Memory array has no reset of its own; it is zeroed by the sequencer.
    // Port B bytes are written before port A so that on a same-address
    // collision A's later assignment wins wherever both enable a byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem[clr_addr_q] <= '0;
            end
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (accept_b && bus.we_b[i]) begin
                    mem[bus.addr_b][i*8 +: 8] <= bus.wdata_b[i*8 +: 8];
                end
                if (accept_a && bus.we_a[i]) begin
                    mem[bus.addr_a][i*8 +: 8] <= bus.wdata_a[i*8 +: 8];
                end
            end
        end
    end

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rd_pipe_a (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept_a),
        .raw_word (raw_a),
        .rdata    (bus.rdata_a),
        .rvalid   (bus.rvalid_a)
    );

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rd_pipe_b (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept_b),
        .raw_word (raw_b),
        .rdata    (bus.rdata_b),
        .rvalid   (bus.rvalid_b)
    );

endmodule

// File: tb/tb_ram_tdp.sv
// tb_ram_tdp
//  Drives two ram_tdp instances with identical stimulus:
//   dut0  OUT_REG=0, read-first
//   dut1  OUT_REG=1, write-first
//  Both use a 16-word x 32-bit array. A word-level reference model predicts
//  ready, and per port the returned word and the cycle it appears.
module tb_ram_tdp;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic          en_a, en_b;
    logic [3:0]    we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;

    int tests_run;
    int tests_failed;

    ram_tdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    ram_tdp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    assign if0.en_a = en_a;  assign if0.we_a = we_a;  assign if0.addr_a = addr_a;  assign if0.wdata_a = wdata_a;
    assign if0.en_b = en_b;  assign if0.we_b = we_b;  assign if0.addr_b = addr_b;  assign if0.wdata_b = wdata_b;
    assign if1.en_a = en_a;  assign if1.we_a = we_a;  assign if1.addr_a = addr_a;  assign if1.wdata_a = wdata_a;
    assign if1.en_b = en_b;  assign if1.we_b = we_b;  assign if1.addr_b = addr_b;  assign if1.wdata_b = wdata_b;

    ram_tdp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .READ_MODE(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (if0)
    );

    ram_tdp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .READ_MODE(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state. Index order for the per-port arrays:
    // 0 = dut0 port A, 1 = dut0 port B, 2 = dut1 port A, 3 = dut1 port B.
    logic [DW-1:0] mdl_mem [DEPTH];
    int            clear_left;
    logic          mdl_ready;
    int            edge_n;
    bit            started;
    logic          sched_v [4][4];
    logic [DW-1:0] sched_d [4][4];
    logic          exp_v   [4];
    logic [DW-1:0] held    [4];

    function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [3:0]    be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Effect of one rising edge on the model, using the inputs as driven.
    task automatic modelEdge();
        logic          acc_a, acc_b;
        logic [DW-1:0] old_a, old_b;
        logic [DW-1:0] rd [4];
        logic          acc [4];
        int            off, slot;
        edge_n++;
        if (rst) begin
            clear_left = DEPTH;
            mdl_ready  = 1'b0;
            started    = 1'b1;
            for (int k = 0; k < 4; k++) begin
                held[k]  = '0;
                exp_v[k] = 1'b0;
                for (int s = 0; s < 4; s++) sched_v[k][s] = 1'b0;
            end
            return;
        end
        acc_a = en_a && mdl_ready;
        acc_b = en_b && mdl_ready;
        old_a = mdl_mem[addr_a];
        old_b = mdl_mem[addr_b];
        rd[0] = old_a;
        rd[1] = old_b;
        rd[2] = mergeBytes(old_a, wdata_a, we_a);
        rd[3] = mergeBytes(old_b, wdata_b, we_b);
        acc[0] = acc_a; acc[1] = acc_b; acc[2] = acc_a; acc[3] = acc_b;
        if (clear_left > 0) begin
            mdl_mem[DEPTH - clear_left] = '0;
            clear_left--;
        end else begin
            if (acc_b) mdl_mem[addr_b] = mergeBytes(mdl_mem[addr_b], wdata_b, we_b);
            if (acc_a) mdl_mem[addr_a] = mergeBytes(mdl_mem[addr_a], wdata_a, we_a);
        end
        mdl_ready = (clear_left == 0);
        for (int k = 0; k < 4; k++) begin
            off = (k < 2) ? 0 : 1;
            if (acc[k]) begin
                slot = (edge_n + off) % 4;
                sched_v[k][slot] = 1'b1;
                sched_d[k][slot] = rd[k];
            end
        end
        for (int k = 0; k < 4; k++) begin
            slot     = edge_n % 4;
            exp_v[k] = sched_v[k][slot];
            if (sched_v[k][slot]) held[k] = sched_d[k][slot];
            sched_v[k][slot] = 1'b0;
        end
    endtask

    task automatic compareAll();
        if (!started) return;
        checkOutput("d0_ready",    32'(if0.ready),    32'(mdl_ready));
        checkOutput("d0_rvalid_a", 32'(if0.rvalid_a), 32'(exp_v[0]));
        checkOutput("d0_rdata_a",  if0.rdata_a,       held[0]);
        checkOutput("d0_rvalid_b", 32'(if0.rvalid_b), 32'(exp_v[1]));
        checkOutput("d0_rdata_b",  if0.rdata_b,       held[1]);
        checkOutput("d1_ready",    32'(if1.ready),    32'(mdl_ready));
        checkOutput("d1_rvalid_a", 32'(if1.rvalid_a), 32'(exp_v[2]));
        checkOutput("d1_rdata_a",  if1.rdata_a,       held[2]);
        checkOutput("d1_rvalid_b", 32'(if1.rvalid_b), 32'(exp_v[3]));
        checkOutput("d1_rdata_b",  if1.rdata_b,       held[3]);
    endtask

    // One clock cycle: drive inputs, let the edge happen, check just after it.
    task automatic applyStimulus(input logic r,
                                 input logic ea, input logic [3:0] wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                                 input logic eb, input logic [3:0] wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        rst = r;
        en_a = ea; we_a = wa; addr_a = aa; wdata_a = da;
        en_b = eb; we_b = wb; addr_b = ab; wdata_b = db;
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
    endtask

    // Count cycles until ready rises, optionally hammering port A with a write
    // to address 2 while waiting. Bounded so a stuck sequencer still finishes.
    task automatic waitReady(input string tag, input int expected, input logic busy_a);
        int cnt;
        cnt = 0;
        while (!(if0.ready === 1'b1 && if1.ready === 1'b1) && cnt < 40) begin
            applyStimulus(0, busy_a, 4'hF, 4'd2, 32'hFFFF_FFFF, 0, 4'h0, '0, '0);
            cnt++;
        end
        checkOutput(tag, 32'(cnt), 32'(expected));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int burst_valid;
        tests_run    = 0;
        tests_failed = 0;
        edge_n       = 0;
        started      = 1'b0;
        clear_left   = 0;
        mdl_ready    = 1'b0;
        for (int k = 0; k < DEPTH; k++) mdl_mem[k] = '0;
        for (int k = 0; k < 4; k++) begin
            held[k] = '0; exp_v[k] = 1'b0;
            for (int s = 0; s < 4; s++) begin sched_v[k][s] = 1'b0; sched_d[k][s] = '0; end
        end

        // Power-up clear
        applyStimulus(1, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
        applyStimulus(1, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
        waitReady("pwrup_ready_cycles", DEPTH, 1'b0);

        // Test 1: fill with ones, reset, expect a full clear
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 4'hF, AW'(i), 32'hFFFF_FFFF, 0, 4'h0, '0, '0);
        applyStimulus(1, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
        waitReady("t1_ready_cycles", DEPTH, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 4'h0, AW'(DEPTH-1-i), '0, 1, 4'h0, AW'(i), '0);
        idle(2);
        checkOutput("t1_d0_last_b", if0.rdata_b, 32'h0);
        checkOutput("t1_d1_last_a", if1.rdata_a, 32'h0);

        // Test 2: byte-enabled write, read back on the other port
        applyStimulus(0, 1, 4'b0101, 4'd3, 32'hAABB_CCDD, 0, 4'h0, '0, '0);
        applyStimulus(0, 0, 4'h0, '0, '0, 1, 4'h0, 4'd3, '0);
        idle(2);
        checkOutput("t2_d0_rdata_b", if0.rdata_b, 32'h00BB_00DD);
        checkOutput("t2_d1_rdata_b", if1.rdata_b, 32'h00BB_00DD);

        // Test 3: read during write, same port and cross port
        applyStimulus(0, 1, 4'hF, 4'd5, 32'h1111_1111, 0, 4'h0, '0, '0);
        applyStimulus(0, 1, 4'hF, 4'd5, 32'h2222_2222, 1, 4'h0, 4'd5, '0);
        idle(2);
        checkOutput("t3_d0_rdw_a",   if0.rdata_a, 32'h1111_1111);
        checkOutput("t3_d1_rdw_a",   if1.rdata_a, 32'h2222_2222);
        checkOutput("t3_d0_cross_b", if0.rdata_b, 32'h1111_1111);
        checkOutput("t3_d1_cross_b", if1.rdata_b, 32'h1111_1111);

        // Test 4: write collision, port A wins shared bytes
        applyStimulus(0, 1, 4'b0011, 4'd7, 32'hAAAA_AAAA, 1, 4'b0110, 4'd7, 32'hBBBB_BBBB);
        applyStimulus(0, 1, 4'h0, 4'd7, '0, 0, 4'h0, '0, '0);
        idle(2);
        checkOutput("t4_d0_collide", if0.rdata_a, 32'h00BB_AAAA);
        checkOutput("t4_d1_collide", if1.rdata_a, 32'h00BB_AAAA);

        // Test 5: back-to-back reads through the pipeline
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 4'h0, '0, '0, 1, 4'hF, AW'(i), 32'(i));
        burst_valid = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) applyStimulus(0, 1, 4'h0, AW'(i), '0, 0, 4'h0, '0, '0);
            else       idle(1);
            if (if1.rvalid_a === 1'b1) burst_valid++;
        end
        checkOutput("t5_d1_burst_valids", 32'(burst_valid), 32'd8);
        checkOutput("t5_d1_last_word",    if1.rdata_a,      32'd7);

        // Test 6: reset mid-clear restarts the sweep; requests during clear ignored
        applyStimulus(0, 1, 4'hF, 4'd2, 32'hFFFF_FFFF, 0, 4'h0, '0, '0);
        applyStimulus(1, 0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 4'hF, 4'd2, 32'hFFFF_FFFF, 0, 4'h0, '0, '0);
        applyStimulus(1, 1, 4'hF, 4'd2, 32'hFFFF_FFFF, 0, 4'h0, '0, '0);
        waitReady("t6_ready_cycles", DEPTH, 1'b1);
        applyStimulus(0, 1, 4'h0, 4'd2, '0, 0, 4'h0, '0, '0);
        idle(2);
        checkOutput("t6_d0_addr2", if0.rdata_a, 32'h0);
        checkOutput("t6_d1_addr2", if1.rdata_a, 32'h0);

        // Randomized traffic over a small address space for frequent conflicts
        for (int k = 0; k < 400; k++) begin
            logic          r, ea, eb;
            logic [3:0]    wa, wb;
            r  = ($urandom_range(0, 149) == 0);
            ea = ($urandom_range(0, 9) < 6);
            eb = ($urandom_range(0, 9) < 6);
            wa = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            wb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            applyStimulus(r, ea, wa, AW'($urandom), $urandom, eb, wb, AW'($urandom), $urandom);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
